// File: rtl/grid_pkg.sv
// grid_pkg
// Shared definitions for the paper-grid removal engine.
//   state_e      : scheduler states IDLE / LOAD / SWEEP / DONE
//   ACCESS_LIMIT : a paper cell with fewer set neighbours than this is removable
//   cnt_width    : width of a removal count for a w x d grid
//   iter_width   : width of a sweep counter that must reach m
//   addr_width   : width of a row address for d rows
package grid_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SWEEP = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam logic [3:0] ACCESS_LIMIT = 4'd4;

  function automatic int cnt_width(input int w, input int d);
    return $clog2(w * d + 1);
  endfunction

  function automatic int iter_width(input int m);
    return (m < 1) ? 1 : $clog2(m + 1);
  endfunction

  // A single-row grid still needs a one-bit address port.
  function automatic int addr_width(input int d);
    return (d < 2) ? 1 : $clog2(d);
  endfunction

endpackage

// File: rtl/remove_accessible.sv
// remove_accessible
// Combinational single removal sweep over a WIDTH x DEPTH grid.
// Every set cell with fewer than ACCESS_LIMIT set cells among its eight
// neighbours is cleared; all decisions use the incoming grid.
// Ports:
//   mat_in      : grid before the sweep, row r bit c = column c
//   mat_out     : grid after the sweep
//   removed     : number of cells cleared by this sweep
//   any_removed : at least one cell was cleared
module remove_accessible
  import grid_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16,
  localparam int CNT_W = cnt_width(WIDTH, DEPTH)
) (
  input  logic [WIDTH-1:0] mat_in  [DEPTH],
  output logic [WIDTH-1:0] mat_out [DEPTH],
  output logic [CNT_W-1:0] removed,
  output logic             any_removed
);

  // Grid framed by a ring of zeros so that edge cells see out-of-grid
  // neighbours as empty without any special-case logic.
  logic [WIDTH+1:0]       pad [DEPTH+2];
  logic [WIDTH*DEPTH-1:0] kill_flat;

  assign pad[0]       = '0;
  assign pad[DEPTH+1] = '0;

  for (genvar r = 0; r < DEPTH; r++) begin : g_row
    logic [WIDTH-1:0] kill_row;

    assign pad[r+1] = {1'b0, mat_in[r], 1'b0};

    // Cell (r,c) sits at pad (r+1,c+1); its neighbourhood spans pad rows
    // r..r+2 and pad bits c..c+2.
    for (genvar c = 0; c < WIDTH; c++) begin : g_col
      logic [3:0] nb;
      assign nb = 4'(pad[r][c])   + 4'(pad[r][c+1])   + 4'(pad[r][c+2])
                + 4'(pad[r+1][c])                     + 4'(pad[r+1][c+2])
                + 4'(pad[r+2][c]) + 4'(pad[r+2][c+1]) + 4'(pad[r+2][c+2]);
      assign kill_row[c] = mat_in[r][c] & (nb < ACCESS_LIMIT);
    end

    assign mat_out[r]                   = mat_in[r] & ~kill_row;
    assign kill_flat[r*WIDTH +: WIDTH]  = kill_row;
  end

  assign removed     = CNT_W'($countones(kill_flat));
  assign any_removed = |kill_flat;

endmodule

// File: rtl/sweep_scheduler.sv
// sweep_scheduler
// Loads a WIDTH x DEPTH paper grid row by row, then applies one removal
// sweep per clock until a sweep removes nothing or MAX_ITER sweeps ran.
// Ports:
//   clk, rst      : clock (rising edge), asynchronous active-high reset
//   start         : begin a job; honoured only in IDLE or DONE
//   load_ready    : high in LOAD; row accepted on load_valid & load_ready
//   load_valid    : load_row carries the next row (row 0 first)
//   load_row      : grid row, bit j = column j, 1 = paper
//   busy          : high in LOAD or SWEEP
//   done          : high throughout DONE
//   timeout       : with done, job was stopped by the sweep limit
//   total_removed : rolls removed over all sweeps of the job
//   iter_count    : sweeps executed, including the final empty sweep
//   rd_addr       : row select for grid readout
//   rd_row        : combinational read of grid row rd_addr
module sweep_scheduler
  import grid_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int DEPTH    = 16,
  parameter int MAX_ITER = 256,
  localparam int CNT_W  = cnt_width(WIDTH, DEPTH),
  localparam int ITER_W = iter_width(MAX_ITER),
  localparam int ADDR_W = addr_width(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              load_ready,
  input  logic              load_valid,
  input  logic [WIDTH-1:0]  load_row,
  output logic              busy,
  output logic              done,
  output logic              timeout,
  output logic [CNT_W-1:0]  total_removed,
  output logic [ITER_W-1:0] iter_count,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  rd_row
);

  state_e state_q, state_d;

  logic [WIDTH-1:0]  grid_q    [DEPTH];
  logic [WIDTH-1:0]  sweep_row [DEPTH];
  logic [CNT_W-1:0]  total_q;
  logic [CNT_W-1:0]  removed;
  logic [ITER_W-1:0] iter_q;
  logic [ADDR_W-1:0] ptr_q;
  logic              timeout_q;
  logic              any_removed;
  logic              last_row;
  logic              iter_limit;

  remove_accessible #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_sweep (
    .mat_in      (grid_q),
    .mat_out     (sweep_row),
    .removed     (removed),
    .any_removed (any_removed)
  );

  assign last_row   = (state_q == LOAD) && load_valid && (ptr_q == ADDR_W'(DEPTH - 1));
  // True when the sweep executing now is the last one allowed.
  assign iter_limit = (({1'b0, iter_q} + 1'b1) == (ITER_W + 1)'(MAX_ITER));

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = LOAD;
      LOAD:    if (last_row) state_d = SWEEP;
      SWEEP:   if (!any_removed || iter_limit) state_d = DONE;
      DONE:    if (start) state_d = LOAD;
      default: state_d = IDLE;
    endcase
  end

  // Moore outputs
  always_comb begin
    load_ready = (state_q == LOAD);
    busy       = (state_q == LOAD) || (state_q == SWEEP);
    done       = (state_q == DONE);
  end

  // Grid, pointer and result registers. The grid is not cleared when a
  // job starts because LOAD overwrites every row before the first sweep.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < DEPTH; r++) grid_q[r] <= '0;
      ptr_q     <= '0;
      total_q   <= '0;
      iter_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            ptr_q     <= '0;
            total_q   <= '0;
            iter_q    <= '0;
            timeout_q <= 1'b0;
          end
        end
        LOAD: begin
          if (load_valid) begin
            grid_q[ptr_q] <= load_row;
            ptr_q         <= last_row ? '0 : ptr_q + 1'b1;
          end
        end
        SWEEP: begin
          for (int r = 0; r < DEPTH; r++) grid_q[r] <= sweep_row[r];
          total_q <= total_q + removed;
          iter_q  <= iter_q + 1'b1;
          if (!any_removed)    timeout_q <= 1'b0;
          else if (iter_limit) timeout_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign timeout       = timeout_q;
  assign total_removed = total_q;
  assign iter_count    = iter_q;
  assign rd_row        = grid_q[rd_addr];

endmodule

// File: tb/tb_sweep_scheduler.sv
// tb_sweep_scheduler
// Drives two 4x4 schedulers with the same load stream: dutA sweeps to
// completion (MAX_ITER=256), dutB stops after one sweep (MAX_ITER=1).
// Expected results are queued when a job is issued; one monitor per DUT
// pops and compares when that DUT's done rises.
module tb_sweep_scheduler;

  typedef struct {
    logic [4:0]  total;
    logic [8:0]  iter;
    logic        tmo;
    logic [15:0] grid;   // {row3,row2,row1,row0}
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       loadValid = 1'b0;
  logic [3:0] loadRow = '0;

  logic       loadReadyA, busyA, doneA, timeoutA;
  logic [4:0] totalA;
  logic [8:0] iterA;
  logic [1:0] rdAddrA = '0;
  logic [3:0] rdRowA;

  logic       loadReadyB, busyB, doneB, timeoutB;
  logic [4:0] totalB;
  logic [0:0] iterB;
  logic [1:0] rdAddrB = '0;
  logic [3:0] rdRowB;

  int vectors = 0;
  int miscompares = 0;
  exp_t qA[$];
  exp_t qB[$];
  logic prevDoneA = 1'b0;
  logic prevDoneB = 1'b0;

  always #5 clk = ~clk;

  sweep_scheduler #(.WIDTH(4), .DEPTH(4), .MAX_ITER(256)) dutA (
    .clk(clk), .rst(rst), .start(start),
    .load_ready(loadReadyA), .load_valid(loadValid), .load_row(loadRow),
    .busy(busyA), .done(doneA), .timeout(timeoutA),
    .total_removed(totalA), .iter_count(iterA),
    .rd_addr(rdAddrA), .rd_row(rdRowA)
  );

  sweep_scheduler #(.WIDTH(4), .DEPTH(4), .MAX_ITER(1)) dutB (
    .clk(clk), .rst(rst), .start(start),
    .load_ready(loadReadyB), .load_valid(loadValid), .load_row(loadRow),
    .busy(busyB), .done(doneB), .timeout(timeoutB),
    .total_removed(totalB), .iter_count(iterB),
    .rd_addr(rdAddrB), .rd_row(rdRowB)
  );

  function automatic void checkOutput(input string name, input logic [31:0] act,
                                      input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endfunction

  function automatic exp_t mk(input logic [4:0] t, input logic [8:0] i,
                              input logic m, input logic [15:0] g);
    exp_t e;
    e.total = t;
    e.iter  = i;
    e.tmo   = m;
    e.grid  = g;
    return e;
  endfunction

  // Monitor for dutA: compares result registers and all grid rows on done rise.
  always @(negedge clk) begin
    logic cur;
    exp_t e;
    cur = doneA;
    if (cur && !prevDoneA) begin
      if (qA.size() == 0) begin
        vectors++;
        miscompares++;
        $display("[TB] FAIL A unexpected done: got done=1, expected no pending job");
      end else begin
        e = qA.pop_front();
        checkOutput("A total_removed", 32'(totalA), 32'(e.total));
        checkOutput("A iter_count", 32'(iterA), 32'(e.iter));
        checkOutput("A timeout", 32'(timeoutA), 32'(e.tmo));
        for (int r = 0; r < 4; r++) begin
          rdAddrA = 2'(r);
          #1;
          checkOutput($sformatf("A row%0d", r), 32'(rdRowA), 32'(e.grid[r*4 +: 4]));
        end
      end
    end
    prevDoneA = cur;
  end

  // Monitor for dutB.
  always @(negedge clk) begin
    logic cur;
    exp_t e;
    cur = doneB;
    if (cur && !prevDoneB) begin
      if (qB.size() == 0) begin
        vectors++;
        miscompares++;
        $display("[TB] FAIL B unexpected done: got done=1, expected no pending job");
      end else begin
        e = qB.pop_front();
        checkOutput("B total_removed", 32'(totalB), 32'(e.total));
        checkOutput("B iter_count", 32'(iterB), 32'(e.iter));
        checkOutput("B timeout", 32'(timeoutB), 32'(e.tmo));
        for (int r = 0; r < 4; r++) begin
          rdAddrB = 2'(r);
          #1;
          checkOutput($sformatf("B row%0d", r), 32'(rdRowB), 32'(e.grid[r*4 +: 4]));
        end
      end
    end
    prevDoneB = cur;
  end

  // Runs one job. rows = {row3,row2,row1,row0}. gaps inserts an idle
  // cycle before each row; pulse raises start during LOAD and SWEEP.
  // abort asserts rst in the first SWEEP cycle; otherwise the number of
  // cycles from the last accepted row to done is compared with expLat.
  task automatic applyStimulus(input logic [15:0] rows, input bit gaps, input bit pulse,
                               input bit abort, input int expLat);
    int lat;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int r = 0; r < 4; r++) begin
      if (gaps) begin
        loadValid = 1'b0;
        loadRow   = 4'hA;
        @(negedge clk);
      end
      loadValid = 1'b1;
      loadRow   = rows[r*4 +: 4];
      start     = pulse;
      @(negedge clk);
      start     = 1'b0;
    end
    loadValid = 1'b0;
    loadRow   = '0;
    if (abort) begin
      rst = 1'b1;
      #1;
      checkOutput("abort busy", 32'(busyA), 32'd0);
      checkOutput("abort done", 32'(doneA), 32'd0);
      checkOutput("abort total_removed", 32'(totalA), 32'd0);
      checkOutput("abort iter_count", 32'(iterA), 32'd0);
      checkOutput("abort B busy", 32'(busyB), 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
    end else begin
      lat = 0;
      start = pulse;
      while (!doneA && lat < 50) begin
        @(negedge clk);
        start = 1'b0;
        lat++;
      end
      start = 1'b0;
      checkOutput("A done latency", 32'(lat), 32'(expLat));
    end
    repeat (3) @(negedge clk);
  endtask

  initial begin
    $display("[TB] sweep_scheduler bench starting");
    repeat (2) @(negedge clk);
    checkOutput("reset busy", 32'(busyA), 32'd0);
    checkOutput("reset done", 32'(doneA), 32'd0);
    checkOutput("reset load_ready", 32'(loadReadyA), 32'd0);
    checkOutput("reset total_removed", 32'(totalA), 32'd0);
    checkOutput("reset iter_count", 32'(iterA), 32'd0);
    checkOutput("reset timeout", 32'(timeoutA), 32'd0);
    checkOutput("reset rd_row", 32'(rdRowA), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // All ones: corners go in sweep 1, nothing in sweep 2.
    qA.push_back(mk(5'd4, 9'd2, 1'b0, 16'h6FF6));
    qB.push_back(mk(5'd4, 9'd1, 1'b1, 16'h6FF6));
    applyStimulus(16'hFFFF, 1'b0, 1'b0, 1'b0, 2);

    // 2x2 block in the corner: each cell has only 3 neighbours.
    qA.push_back(mk(5'd4, 9'd2, 1'b0, 16'h0000));
    qB.push_back(mk(5'd4, 9'd1, 1'b1, 16'h0000));
    applyStimulus(16'h0033, 1'b0, 1'b0, 1'b0, 2);

    // Empty grid: a single zero-removal sweep.
    qA.push_back(mk(5'd0, 9'd1, 1'b0, 16'h0000));
    qB.push_back(mk(5'd0, 9'd1, 1'b0, 16'h0000));
    applyStimulus(16'h0000, 1'b0, 1'b0, 1'b0, 1);

    // All ones again with load gaps and start pulses in LOAD and SWEEP.
    qA.push_back(mk(5'd4, 9'd2, 1'b0, 16'h6FF6));
    qB.push_back(mk(5'd4, 9'd1, 1'b1, 16'h6FF6));
    applyStimulus(16'hFFFF, 1'b1, 1'b1, 1'b0, 2);

    // Reset in the first sweep cycle, then a clean rerun.
    applyStimulus(16'hFFFF, 1'b0, 1'b0, 1'b1, 0);
    qA.push_back(mk(5'd4, 9'd2, 1'b0, 16'h6FF6));
    qB.push_back(mk(5'd4, 9'd1, 1'b1, 16'h6FF6));
    applyStimulus(16'hFFFF, 1'b0, 1'b0, 1'b0, 2);

    repeat (2) @(negedge clk);
    checkOutput("A pending results", 32'(qA.size()), 32'd0);
    checkOutput("B pending results", 32'(qB.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no completion, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/sweep_scheduler.md
Name: sweep_scheduler

Overview:
- Sequencing controller for the one-sweep `remove_accessible` datapath.
- Loads a WIDTH x DEPTH paper grid row by row into an internal register array. It then applies one removal sweep per clock until a sweep removes nothing, or until an iteration limit is hit.
- Reports the total rolls removed, the sweeps executed and the final grid.
- Top-level engine behind the exhaustive-removal result; replaces ad-hoc looping around the combinational sweep.

Parameters:
- WIDTH, 16, columns per row (bits per row word).
- DEPTH, 16, number of rows.
- MAX_ITER, 256, sweep limit before forced stop (timeout).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle request to begin a job; honoured only in IDLE or DONE.
- load_ready  out  1  high in LOAD; a row is accepted when load_valid & load_ready.
- load_valid  in  1  load_row is valid.
- load_row  in  WIDTH  next grid row, row 0 first; bit j = column j; 1 = paper.
- busy  out  1  high in LOAD or SWEEP.
- done  out  1  high throughout DONE.
- timeout  out  1  valid with done; 1 if stopped by MAX_ITER.
- total_removed  out  $clog2(WIDTH*DEPTH+1)  accumulated removals.
- iter_count  out  $clog2(MAX_ITER+1)  sweeps executed, including the final zero-removal sweep.
- rd_addr  in  $clog2(DEPTH)  row select for grid readout.
- rd_row  out  WIDTH  combinational read of grid register row rd_addr, valid in any state.

Behaviour:
- Reset (async, rst=1):
  - State is IDLE; grid registers, total_removed, iter_count, load row pointer and timeout all clear to 0.
  - load_ready, busy and done are 0.
- FSM states: IDLE, LOAD, SWEEP, DONE.
- IDLE:
  - start=1 -> LOAD.
  - Row pointer, total_removed, iter_count and timeout clear on the transition.
- LOAD:
  - load_ready=1.
  - Each accepted row is written to grid[ptr] and ptr increments.
  - Gaps in load_valid are allowed.
  - When the row with ptr==DEPTH-1 is accepted -> SWEEP on the next cycle.
  - start is ignored.
- SWEEP:
  - One sweep per cycle: grid <= mat_out of the sub-module, total_removed += removed, iter_count += 1.
  - If any_removed==0 this cycle -> DONE, timeout=0.
  - Else if iter_count+1 == MAX_ITER -> DONE, timeout=1.
  - Else stay in SWEEP.
  - start is ignored.
- DONE:
  - done=1; outputs and grid are held.
  - start=1 -> LOAD, with counters cleared as from IDLE.
- Latency: the first sweep executes in the cycle after the last row is accepted. done rises the cycle after the terminating sweep.
- Arithmetic:
  - total_removed cannot overflow; it is bounded by WIDTH*DEPTH.
  - iter_count saturates at MAX_ITER by construction.
- Sweep rule, evaluated by the sub-module: a set cell with fewer than 4 set neighbours (8-neighbourhood, out-of-grid counts as 0) is cleared. All cells in a sweep use the pre-sweep grid.
- Empty grid: one sweep, removed=0 -> DONE, iter_count=1, total_removed=0.
- A reset asserted mid-LOAD or mid-SWEEP aborts the job immediately and returns to the reset values. No partial result is retained.

Decomposition:
- Shared package `grid_pkg`:
  - State enum {IDLE, LOAD, SWEEP, DONE}.
  - Localparam width functions for the count (clog2(W*D+1)), iteration and address widths.
  - Neighbour threshold constant ACCESS_LIMIT=4, also used by `remove_accessible`.
- Sub-module: reuse `remove_accessible` (combinational single sweep), instantiated once and fed by the grid register array.
- No other sub-modules.

Test Plan (WIDTH=4, DEPTH=4 unless noted):
- Load all-ones 4x4 rows {F,F,F,F}, MAX_ITER=256 -> corners removed in sweep 1, zero in sweep 2; done with total_removed=4, iter_count=2, timeout=0, final rows {6,F,F,6}.
- Load 2x2 block rows {3,3,0,0} -> all 4 cells removed in sweep 1; done with total_removed=4, iter_count=2, final grid all 0.
- Load empty grid {0,0,0,0} -> done 1 cycle after the sweep begins; total_removed=0, iter_count=1, timeout=0.
- All-ones 4x4 with MAX_ITER=1 -> done with timeout=1, total_removed=4, iter_count=1.
- LOAD with load_valid toggling 1,0,1,0 and start pulsed during LOAD/SWEEP -> exactly DEPTH rows captured in order; start has no effect; results match the first scenario.
- Assert rst during SWEEP of the all-ones job -> same cycle: busy=0, done=0, total_removed=0; then a fresh start and load reproduces total_removed=4.
